// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged branch target buffer for the fetch stage.
// Combinational lookup forms the predicted next PC; resolved EX outcomes write entries.
module branch_target_buffer #(
  parameter int unsigned ENTRY_BITS = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            bp_prediction,
  output logic            btb_hit,
  output logic            btb_is_jump,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [XLEN-1:0] next_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  output logic [31:0]     lookup_count,
  output logic [31:0]     hit_count
);

  localparam int unsigned ENTRIES = 1 << ENTRY_BITS;
  localparam int unsigned TAG_W   = XLEN - ENTRY_BITS - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];

  logic [ENTRY_BITS-1:0] fetch_idx;
  logic [TAG_W-1:0]      fetch_tag;
  logic [ENTRY_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_write;
  logic                  unused_upd_lsb;

  assign fetch_idx      = fetch_pc[ENTRY_BITS+1:2];
  assign fetch_tag      = fetch_pc[XLEN-1:ENTRY_BITS+2];
  assign upd_idx        = upd_pc[ENTRY_BITS+1:2];
  assign upd_tag        = upd_pc[XLEN-1:ENTRY_BITS+2];
  assign unused_upd_lsb = ^upd_pc[1:0];

  // A not-taken jump cannot occur; it is written as if taken.
  assign upd_write = upd_valid && (upd_taken || upd_is_jump);

  // Lookup against current table state (no bypass from a same-cycle update).
  always_comb begin
    btb_hit     = 1'b0;
    btb_is_jump = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    if (fetch_valid && valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag)) begin
      btb_hit     = 1'b1;
      btb_is_jump = jump_q[fetch_idx];
      pred_target = target_q[fetch_idx];
      pred_taken  = jump_q[fetch_idx] || bp_prediction;
    end
    next_pc = pred_taken ? pred_target : (fetch_pc + XLEN'(4));
  end

  // Valid bits are the only table state that needs clearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (upd_write) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && upd_write) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
      jump_q[upd_idx]   <= upd_is_jump;
    end
  end

  // Performance counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      lookup_count <= '0;
      hit_count    <= '0;
    end else begin
      if (fetch_valid) lookup_count <= lookup_count + 32'd1;
      if (btb_hit)     hit_count    <= hit_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: each task drives one scenario and checks
// against hand-computed values.
module tb_branch_target_buffer;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        bp_prediction;
  logic        btb_hit;
  logic        btb_is_jump;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] lookup_count;
  logic [31:0] hit_count;

  int tests_run = 0;
  int tests_failed = 0;

  branch_target_buffer #(.ENTRY_BITS(4), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .bp_prediction(bp_prediction),
    .btb_hit(btb_hit), .btb_is_jump(btb_is_jump), .pred_taken(pred_taken),
    .pred_target(pred_target), .next_pc(next_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .lookup_count(lookup_count), .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic jmp, input logic tkn);
    upd_valid = v; upd_pc = pc; upd_target = tgt; upd_is_jump = jmp; upd_taken = tkn;
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] pc, input logic bp);
    fetch_valid = v; fetch_pc = pc; bp_prediction = bp;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_fetch(1'b1, 32'h100, 1'b1);
    step();
    reset = 1'b0;
    #1;
    tests_run++; if (btb_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_hit got %0b want 0", btb_hit); end
    tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
    tests_run++; if (btb_is_jump !== 1'b0) begin tests_failed++; $display("FAIL reset_is_jump got %0b want 0", btb_is_jump); end
    tests_run++; if (pred_target !== 32'h0) begin tests_failed++; $display("FAIL reset_target got %h want 0", pred_target); end
    tests_run++; if (next_pc !== 32'h104) begin tests_failed++; $display("FAIL reset_next_pc got %h want 104", next_pc); end
    tests_run++; if (lookup_count !== 32'd0) begin tests_failed++; $display("FAIL reset_lookup_count got %0d want 0", lookup_count); end
    tests_run++; if (hit_count !== 32'd0) begin tests_failed++; $display("FAIL reset_hit_count got %0d want 0", hit_count); end
    step();
    fetch_valid = 1'b0;
    tests_run++; if (lookup_count !== 32'd1) begin tests_failed++; $display("FAIL first_lookup_count got %0d want 1", lookup_count); end
    tests_run++; if (hit_count !== 32'd0) begin tests_failed++; $display("FAIL first_hit_count got %0d want 0", hit_count); end
  endtask

  task automatic test_taken_branch();
    set_upd(1'b1, 32'h100, 32'h200, 1'b0, 1'b1);
    set_fetch(1'b0, 32'h0, 1'b0);
    step();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_fetch(1'b1, 32'h100, 1'b1);
    tests_run++; if (btb_hit !== 1'b1) begin tests_failed++; $display("FAIL branch_hit got %0b want 1", btb_hit); end
    tests_run++; if (pred_target !== 32'h200) begin tests_failed++; $display("FAIL branch_target got %h want 200", pred_target); end
    tests_run++; if (next_pc !== 32'h200) begin tests_failed++; $display("FAIL branch_taken_next got %h want 200", next_pc); end
    tests_run++; if (btb_is_jump !== 1'b0) begin tests_failed++; $display("FAIL branch_is_jump got %0b want 0", btb_is_jump); end
    set_fetch(1'b1, 32'h100, 1'b0);
    tests_run++; if (next_pc !== 32'h104) begin tests_failed++; $display("FAIL branch_nt_next got %h want 104", next_pc); end
    tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL branch_nt_pred got %0b want 0", pred_taken); end
    tests_run++; if (btb_hit !== 1'b1) begin tests_failed++; $display("FAIL branch_nt_hit got %0b want 1", btb_hit); end
    set_fetch(1'b0, 32'h100, 1'b1);
    tests_run++; if (btb_hit !== 1'b0) begin tests_failed++; $display("FAIL fetch_invalid_hit got %0b want 0", btb_hit); end
    tests_run++; if (next_pc !== 32'h104) begin tests_failed++; $display("FAIL fetch_invalid_next got %h want 104", next_pc); end
  endtask

  task automatic test_jump();
    set_upd(1'b1, 32'h40, 32'h80, 1'b1, 1'b1);
    set_fetch(1'b0, 32'h0, 1'b0);
    step();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_fetch(1'b1, 32'h40, 1'b0);
    tests_run++; if (pred_taken !== 1'b1) begin tests_failed++; $display("FAIL jump_pred_taken got %0b want 1", pred_taken); end
    tests_run++; if (next_pc !== 32'h80) begin tests_failed++; $display("FAIL jump_next got %h want 80", next_pc); end
    tests_run++; if (btb_is_jump !== 1'b1) begin tests_failed++; $display("FAIL jump_is_jump got %0b want 1", btb_is_jump); end
  endtask

  task automatic test_alias();
    // 0x100 and 0x140 share index 0; 0x40 also maps there and is evicted first.
    set_upd(1'b1, 32'h100, 32'h200, 1'b0, 1'b1);
    set_fetch(1'b0, 32'h0, 1'b0);
    step();
    set_upd(1'b1, 32'h140, 32'h300, 1'b0, 1'b1);
    set_fetch(1'b1, 32'h140, 1'b1);
    tests_run++; if (btb_hit !== 1'b0) begin tests_failed++; $display("FAIL alias_same_cycle_hit got %0b want 0", btb_hit); end
    tests_run++; if (next_pc !== 32'h144) begin tests_failed++; $display("FAIL alias_same_cycle_next got %h want 144", next_pc); end
    step();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_fetch(1'b1, 32'h100, 1'b1);
    tests_run++; if (btb_hit !== 1'b0) begin tests_failed++; $display("FAIL alias_evicted_hit got %0b want 0", btb_hit); end
    tests_run++; if (next_pc !== 32'h104) begin tests_failed++; $display("FAIL alias_evicted_next got %h want 104", next_pc); end
    set_fetch(1'b1, 32'h140, 1'b1);
    tests_run++; if (btb_hit !== 1'b1) begin tests_failed++; $display("FAIL alias_new_hit got %0b want 1", btb_hit); end
    tests_run++; if (pred_target !== 32'h300) begin tests_failed++; $display("FAIL alias_new_target got %h want 300", pred_target); end
    set_fetch(1'b1, 32'h40, 1'b0);
    tests_run++; if (btb_hit !== 1'b0) begin tests_failed++; $display("FAIL alias_jump_evicted got %0b want 0", btb_hit); end
  endtask

  task automatic test_not_taken();
    set_upd(1'b1, 32'h100, 32'h200, 1'b0, 1'b1);
    set_fetch(1'b0, 32'h0, 1'b0);
    step();
    set_upd(1'b1, 32'h100, 32'h999, 1'b0, 1'b0);
    step();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_fetch(1'b1, 32'h100, 1'b1);
    tests_run++; if (btb_hit !== 1'b1) begin tests_failed++; $display("FAIL nt_retained_hit got %0b want 1", btb_hit); end
    tests_run++; if (next_pc !== 32'h200) begin tests_failed++; $display("FAIL nt_retained_next got %h want 200", next_pc); end
    set_fetch(1'b1, 32'hFFFF_FFFC, 1'b1);
    tests_run++; if (btb_hit !== 1'b0) begin tests_failed++; $display("FAIL wrap_hit got %0b want 0", btb_hit); end
    tests_run++; if (next_pc !== 32'h0) begin tests_failed++; $display("FAIL wrap_next got %h want 0", next_pc); end
    // A not-taken jump is written as a taken jump.
    set_upd(1'b1, 32'h84, 32'h500, 1'b1, 1'b0);
    set_fetch(1'b0, 32'h0, 1'b0);
    step();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_fetch(1'b1, 32'h84, 1'b0);
    tests_run++; if (btb_hit !== 1'b1) begin tests_failed++; $display("FAIL illegal_jump_hit got %0b want 1", btb_hit); end
    tests_run++; if (next_pc !== 32'h500) begin tests_failed++; $display("FAIL illegal_jump_next got %h want 500", next_pc); end
    tests_run++; if (btb_is_jump !== 1'b1) begin tests_failed++; $display("FAIL illegal_jump_flag got %0b want 1", btb_is_jump); end
    set_fetch(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    reset = 1'b1;
    set_upd(1'b1, 32'h8, 32'h900, 1'b0, 1'b1);
    set_fetch(1'b1, 32'h100, 1'b1);
    step();
    reset = 1'b0;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_fetch(1'b1, 32'h100, 1'b1);
    tests_run++; if (btb_hit !== 1'b0) begin tests_failed++; $display("FAIL midreset_100_hit got %0b want 0", btb_hit); end
    set_fetch(1'b1, 32'h84, 1'b1);
    tests_run++; if (btb_hit !== 1'b0) begin tests_failed++; $display("FAIL midreset_84_hit got %0b want 0", btb_hit); end
    set_fetch(1'b1, 32'h8, 1'b1);
    tests_run++; if (btb_hit !== 1'b0) begin tests_failed++; $display("FAIL midreset_dropped_hit got %0b want 0", btb_hit); end
    tests_run++; if (next_pc !== 32'hC) begin tests_failed++; $display("FAIL midreset_dropped_next got %h want c", next_pc); end
    tests_run++; if (lookup_count !== 32'd0) begin tests_failed++; $display("FAIL midreset_lookup_count got %0d want 0", lookup_count); end
    tests_run++; if (hit_count !== 32'd0) begin tests_failed++; $display("FAIL midreset_hit_count got %0d want 0", hit_count); end
  endtask

  task automatic test_counters();
    // Lookup of 0x100 while it is being written (miss), then a hit, then an idle cycle.
    set_upd(1'b1, 32'h100, 32'h200, 1'b0, 1'b1);
    set_fetch(1'b1, 32'h100, 1'b1);
    step();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_fetch(1'b1, 32'h100, 1'b1);
    tests_run++; if (btb_hit !== 1'b1) begin tests_failed++; $display("FAIL count_hit got %0b want 1", btb_hit); end
    step();
    set_fetch(1'b0, 32'h100, 1'b1);
    step();
    tests_run++; if (lookup_count !== 32'd2) begin tests_failed++; $display("FAIL count_lookups got %0d want 2", lookup_count); end
    tests_run++; if (hit_count !== 32'd1) begin tests_failed++; $display("FAIL count_hits got %0d want 1", hit_count); end
  endtask

  initial begin
    reset = 1'b1;
    fetch_valid = 1'b0; fetch_pc = '0; bp_prediction = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
    test_reset();
    test_taken_branch();
    test_jump();
    test_alias();
    test_not_taken();
    test_reset_mid_op();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
